instruction_encoder: RTL and testbench

- Streaming RV32I encoder, the inverse of the control decoder. Turns abstract ops (mnemonic plus register and immediate fields) into 32-bit machine words.
- Writes each word into instruction memory at consecutive word addresses.
- Used by the boot/program loader and by benches to build programs for the core.
- Covers the same subset the core decodes: ADD, SUB, ADDI, LW, SW, BEQ.

---
 rtl/instruction_encoder_pkg.sv | 50 +++++
 rtl/instruction_encoder_word_pack.sv | 49 ++++
 rtl/instruction_encoder.sv | 147 ++++++++++++++
 tb/tb_instruction_encoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32I encoding constants and types for the instruction encoder
// and the core's control decoder.
package instruction_encoder_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADDI = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_BEQ  = 3'd5
  } enc_op_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_ILLEGAL_OP = 2'd1,
    ERR_IMM_RANGE  = 2'd2,
    ERR_OVERFLOW   = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERROR  = 2'd3
  } enc_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  // True when imm, read as two's complement, fits a signed field of 'bits' width.
  function automatic logic imm_fits(input logic [31:0] imm, input int bits);
    logic signed [31:0] s_lim;
    s_lim = 32'sd1 <<< (bits - 1);
    return ($signed(imm) >= -s_lim) && ($signed(imm) < s_lim);
  endfunction

endpackage

// File: rtl/instruction_encoder_word_pack.sv
// Combinational packer: one abstract op in, one RV32I word out, together
// with the illegal-op and immediate-range flags.
module instr_word_pack
  import instruction_encoder_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_illegal,
  output logic        o_imm_range
);

  enc_op_t w_op;
  assign w_op = enc_op_t'(i_op);

  // Word assembly and field checks per instruction format
  always_comb begin
    o_word      = 32'd0;
    o_illegal   = 1'b0;
    o_imm_range = 1'b0;
    case (w_op)
      OP_ADD: o_word = {F7_ADD, i_rs2, i_rs1, F3_ADD, i_rd, OPC_OP};
      OP_SUB: o_word = {F7_SUB, i_rs2, i_rs1, F3_ADD, i_rd, OPC_OP};
      OP_ADDI: begin
        o_word      = {i_imm[11:0], i_rs1, F3_ADDI, i_rd, OPC_OPIMM};
        o_imm_range = !imm_fits(i_imm, 12);
      end
      OP_LW: begin
        o_word      = {i_imm[11:0], i_rs1, F3_LW, i_rd, OPC_LOAD};
        o_imm_range = !imm_fits(i_imm, 12);
      end
      OP_SW: begin
        o_word      = {i_imm[11:5], i_rs2, i_rs1, F3_SW, i_imm[4:0], OPC_STORE};
        o_imm_range = !imm_fits(i_imm, 12);
      end
      OP_BEQ: begin
        // Branch offsets are halfword-granular, so bit 0 must be clear
        o_word      = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, F3_BEQ,
                       i_imm[4:1], i_imm[11], OPC_BRANCH};
        o_imm_range = !imm_fits(i_imm, 13) || i_imm[0];
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streaming RV32I program encoder: accepts abstract ops, writes encoded
// words to consecutive instruction-memory addresses.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [2:0]             op,
  input  logic [4:0]             rd,
  input  logic [4:0]             rs1,
  input  logic [4:0]             rs2,
  input  logic [31:0]            imm,
  input  logic                   last,
  output logic                   imem_we,
  output logic [31:0]            imem_addr,
  output logic [31:0]            imem_wdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             err_code
);

  localparam int CW = $clog2(DEPTH) + 1;

  enc_state_e r_state, w_state_nxt;
  logic          r_we, w_we_nxt;
  logic [31:0]   r_addr, w_addr_nxt;
  logic [31:0]   r_wdata, w_wdata_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_done, w_done_nxt;
  logic          r_error, w_error_nxt;
  err_code_e     r_err_code, w_err_code_nxt;

  logic [31:0]   w_word;
  logic          w_illegal;
  logic          w_imm_range;
  logic          w_accept;
  logic [CW-1:0] w_count_inc;

  instr_word_pack u_pack (
    .i_op        (op),
    .i_rd        (rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .i_imm       (imm),
    .o_word      (w_word),
    .o_illegal   (w_illegal),
    .o_imm_range (w_imm_range)
  );

  assign op_ready    = (r_state == ST_ENCODE);
  assign w_accept    = op_valid && op_ready;
  assign w_count_inc = r_count + CW'(1);

  // Next-state and next-output computation for the encoder FSM
  always_comb begin
    w_state_nxt    = r_state;
    w_we_nxt       = 1'b0;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_count_nxt    = r_count;
    w_done_nxt     = r_done;
    w_error_nxt    = r_error;
    w_err_code_nxt = r_err_code;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          w_state_nxt    = ST_ENCODE;
          w_count_nxt    = {CW{1'b0}};
          w_done_nxt     = 1'b0;
          w_error_nxt    = 1'b0;
          w_err_code_nxt = ERR_NONE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ENCODE: begin
        if (!w_accept) begin
          w_state_nxt = r_state;
        end else if (w_illegal) begin
          w_state_nxt    = ST_ERROR;
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_ILLEGAL_OP;
        end else if (w_imm_range) begin
          w_state_nxt    = ST_ERROR;
          w_error_nxt    = 1'b1;
          w_err_code_nxt = ERR_IMM_RANGE;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = BASE_ADDR + (32'(r_count) << 2);
          w_wdata_nxt = w_word;
          w_count_nxt = w_count_inc;
          // last wins over a simultaneous capacity hit
          if (last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else if (w_count_inc == CW'(DEPTH)) begin
            w_state_nxt    = ST_ERROR;
            w_error_nxt    = 1'b1;
            w_err_code_nxt = ERR_OVERFLOW;
          end else begin
            w_state_nxt = ST_ENCODE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_count    <= {CW{1'b0}};
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_count    <= w_count_nxt;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign count      = r_count;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed scoreboard bench for instruction_encoder: a default-depth DUT and
// a DEPTH=4 DUT share op inputs but have separate start strobes.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        start_s = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  rs1 = 5'd0;
  logic [4:0]  rs2 = 5'd0;
  logic [31:0] imm = 32'd0;
  logic        last = 1'b0;

  logic        op_ready, imem_we, done, error;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  count;
  logic [1:0]  err_code;

  logic        op_ready_s, imem_we_s, done_s, error_s;
  logic [31:0] imem_addr_s, imem_wdata_s;
  logic [2:0]  count_s;
  logic [1:0]  err_code_s;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [63:0] q_big[$];
  logic [63:0] q_sm[$];

  logic [2:0]  r_o;
  logic [4:0]  r_d, r_s1, r_s2;
  logic [31:0] r_im;

  always #5 clk = ~clk;

  instruction_encoder #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_valid(op_valid),
    .op_ready(op_ready), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .last(last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .count(count), .done(done), .error(error),
    .err_code(err_code)
  );

  instruction_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start_s), .op_valid(op_valid),
    .op_ready(op_ready_s), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .last(last), .imem_we(imem_we_s), .imem_addr(imem_addr_s),
    .imem_wdata(imem_wdata_s), .count(count_s), .done(done_s),
    .error(error_s), .err_code(err_code_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference encoding for the ops used in the random phase
  function automatic logic [31:0] model(input logic [2:0] o, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [31:0] im);
    case (o)
      3'd0:    return {7'b0000000, s2, s1, 3'b000, d, 7'b0110011};
      3'd1:    return {7'b0100000, s2, s1, 3'b000, d, 7'b0110011};
      default: return {im[11:0], s1, 3'b000, d, 7'b0010011};
    endcase
  endfunction

  // Scoreboard pop for the default-depth DUT
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (q_big.size() == 0) chk("unexpected_write", 32'(imem_we), 32'd0);
      else begin
        logic [63:0] e;
        e = q_big.pop_front();
        chk("wr_addr", imem_addr, e[63:32]);
        chk("wr_data", imem_wdata, e[31:0]);
      end
    end
  end

  // Scoreboard pop for the DEPTH=4 DUT
  always @(negedge clk) begin
    if (imem_we_s === 1'b1) begin
      if (q_sm.size() == 0) chk("unexpected_write_s", 32'(imem_we_s), 32'd0);
      else begin
        logic [63:0] e;
        e = q_sm.pop_front();
        chk("wr_addr_s", imem_addr_s, e[63:32]);
        chk("wr_data_s", imem_wdata_s, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sm);
    if (sm) start_s = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic send(input bit sm, input logic [2:0] o, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input bit l, input bit wr,
                      input logic [31:0] a, input logic [31:0] w, input bit rdy);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l; op_valid = 1'b1;
    if (sm) chk("op_ready_s", 32'(op_ready_s), 32'(rdy));
    else    chk("op_ready", 32'(op_ready), 32'(rdy));
    if (wr) begin
      if (sm) q_sm.push_back({a, w});
      else    q_big.push_back({a, w});
    end
    tick();
    op_valid = 1'b0;
    last = 1'b0;
  endtask

  task automatic drain();
    repeat (2) tick();
    chk("sb_empty", 32'(q_big.size()), 32'd0);
    chk("sb_empty_s", 32'(q_sm.size()), 32'd0);
  endtask

  initial begin
    // Reset values
    #1 reset_n = 1'b0;
    #2;
    chk("rst_op_ready", 32'(op_ready), 32'd0);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("idle_no_ready", 32'(op_ready), 32'd0);

    // ADD then SUB(last)
    pulse_start(1'b0);
    send(1'b0, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h0, 32'h002081B3, 1'b1);
    send(1'b0, 3'd1, 5'd5, 5'd6, 5'd7, 32'd0, 1'b1, 1'b1, 32'h4, 32'h407302B3, 1'b1);
    chk("t1_done_in_write_cycle", 32'({done, imem_we}), 32'd3);
    chk("t1_count", 32'(count), 32'd2);
    chk("t1_ready_dropped", 32'(op_ready), 32'd0);
    drain();

    // Back-to-back four-format program
    pulse_start(1'b0);
    chk("t2_count_cleared", 32'(count), 32'd0);
    chk("t2_done_cleared", 32'(done), 32'd0);
    send(1'b0, 3'd2, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, 32'hFFF00093, 1'b1);
    send(1'b0, 3'd3, 5'd2, 5'd1, 5'd0, 32'd8, 1'b0, 1'b1, 32'h4, 32'h0080A103, 1'b1);
    send(1'b0, 3'd4, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0, 1'b1, 32'h8, 32'h0020A623, 1'b1);
    send(1'b0, 3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'hC, 32'hFE208CE3, 1'b1);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_count", 32'(count), 32'd4);
    drain();

    // Error paths: ADDI 2048, BEQ -7, op 6
    pulse_start(1'b0);
    send(1'b0, 3'd2, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t3_addi_error", 32'(error), 32'd1);
    chk("t3_addi_code", 32'(err_code), 32'd2);
    chk("t3_addi_no_we", 32'(imem_we), 32'd0);
    pulse_start(1'b0);
    chk("t3_start_clears_error", 32'(error), 32'd0);
    send(1'b0, 3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF9, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t3_beq_error", 32'(error), 32'd1);
    chk("t3_beq_code", 32'(err_code), 32'd2);
    pulse_start(1'b0);
    send(1'b0, 3'd6, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("t3_illegal_error", 32'(error), 32'd1);
    chk("t3_illegal_code", 32'(err_code), 32'd1);
    chk("t3_illegal_count", 32'(count), 32'd0);
    pulse_start(1'b0);
    chk("t3_cleared_error", 32'(error), 32'd0);
    chk("t3_cleared_code", 32'(err_code), 32'd0);
    send(1'b0, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b1, 32'h0,
         model(3'd0, 5'd1, 5'd1, 5'd1, 32'd0), 1'b1);
    drain();

    // Capacity on DEPTH=4: overflow without last, then clean finish with last
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 3'd2, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0, 1'b1, 32'(4 * i),
           model(3'd2, 5'(i + 1), 5'd0, 5'd0, 32'(i)), 1'b1);
    end
    chk("t4_ovf_error", 32'(error_s), 32'd1);
    chk("t4_ovf_code", 32'(err_code_s), 32'd3);
    chk("t4_ovf_count", 32'(count_s), 32'd4);
    send(1'b1, 3'd2, 5'd9, 5'd0, 5'd0, 32'd9, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drain();
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 3'd0, 5'(i), 5'd2, 5'd3, 32'd0, (i == 3), 1'b1, 32'(4 * i),
           model(3'd0, 5'(i), 5'd2, 5'd3, 32'd0), 1'b1);
    end
    chk("t4_last_done", 32'(done_s), 32'd1);
    chk("t4_last_no_error", 32'(error_s), 32'd0);
    drain();

    // Reset mid-stream with op_valid held high
    pulse_start(1'b0);
    op = 3'd0; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3; imm = 32'd0; last = 1'b0;
    op_valid = 1'b1;
    q_big.push_back({32'h0, model(3'd0, 5'd1, 5'd2, 5'd3, 32'd0)});
    q_big.push_back({32'h4, model(3'd0, 5'd1, 5'd2, 5'd3, 32'd0)});
    tick();
    tick();
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_we", 32'(imem_we), 32'd0);
    chk("t5_rst_addr", imem_addr, 32'd0);
    chk("t5_rst_wdata", imem_wdata, 32'd0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_ready", 32'(op_ready), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("t5_idle_after_release", 32'(op_ready), 32'd0);
    chk("t5_count_after_release", 32'(count), 32'd0);
    op_valid = 1'b0;
    drain();

    // Random idle gaps; one op carries a start that must be ignored
    pulse_start(1'b0);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      r_o  = 3'($urandom_range(0, 2));
      r_d  = 5'($urandom);
      r_s1 = 5'($urandom);
      r_s2 = 5'($urandom);
      r_im = 32'($urandom_range(0, 4095)) - 32'd2048;
      if (i == 5) start = 1'b1;
      send(1'b0, r_o, r_d, r_s1, r_s2, r_im, (i == 19), 1'b1, 32'(4 * i),
           model(r_o, r_d, r_s1, r_s2, r_im), 1'b1);
      start = 1'b0;
    end
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_count", 32'(count), 32'd20);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
